// File: rtl/pipe_register.sv
// n-bit storage register with write enable and synchronous active-low clear (optional parity: REGISTER_PARITY_EN).
// Latency: 1 cycle from i_data/i_clear_n to o_out (and o_par).
// Backpressure: none; i_en is a pure qualifier and o_out is always valid.
module pipe_register #(
    parameter int unsigned    n         = 32,
    parameter logic [n-1:0]   RESET_VAL = '0
) (
    input  logic         i_core_clk,
    input  logic         i_clear_n,
    input  logic [n-1:0] i_data,
    input  logic         i_en,
`ifdef REGISTER_PARITY_EN
    output logic         o_par,
`endif
    output logic [n-1:0] o_out
);

    logic [n-1:0] r_q;

    // Clear beats write enable on the same edge.
    always_ff @(posedge i_core_clk) begin
        if (!i_clear_n) begin
            r_q <= RESET_VAL;
        end else if (i_en) begin
            r_q <= i_data;
        end
    end

    assign o_out = r_q;

`ifdef REGISTER_PARITY_EN
    logic r_par;

    always_ff @(posedge i_core_clk) begin
        if (!i_clear_n) begin
            r_par <= ^RESET_VAL;
        end else if (i_en) begin
            r_par <= ^i_data;
        end
    end

    // Nonzero only when the stored word no longer matches the parity captured with it.
    assign o_par = r_par ^ (^r_q);
`endif

endmodule

// File: tb/tb_pipe_register.sv
// Directed bench for pipe_register: four instances (n=32 zero reset, n=32 reset 0x10, n=4, n=1)
// share control; expected values are queued when driven and checked after the edge.
module tb_pipe_register;

    logic        clk = 1'b0;
    logic        clear_n;
    logic        en;
    logic [31:0] d32;
    logic [3:0]  d4;
    logic        d1;

    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [3:0]  out_c;
    logic        out_e;
    logic        par_a;
    logic        par_b;
    logic        par_c;
    logic        par_e;

    always #5 clk = ~clk;

    pipe_register #(.n(32)) dut_a (
        .i_core_clk(clk), .i_clear_n(clear_n), .i_data(d32), .i_en(en),
`ifdef REGISTER_PARITY_EN
        .o_par(par_a),
`endif
        .o_out(out_a)
    );

    pipe_register #(.n(32), .RESET_VAL(32'h0000_0010)) dut_b (
        .i_core_clk(clk), .i_clear_n(clear_n), .i_data(d32), .i_en(en),
`ifdef REGISTER_PARITY_EN
        .o_par(par_b),
`endif
        .o_out(out_b)
    );

    pipe_register #(.n(4)) dut_c (
        .i_core_clk(clk), .i_clear_n(clear_n), .i_data(d4), .i_en(en),
`ifdef REGISTER_PARITY_EN
        .o_par(par_c),
`endif
        .o_out(out_c)
    );

    pipe_register #(.n(1)) dut_e (
        .i_core_clk(clk), .i_clear_n(clear_n), .i_data(d1), .i_en(en),
`ifdef REGISTER_PARITY_EN
        .o_par(par_e),
`endif
        .o_out(out_e)
    );

`ifndef REGISTER_PARITY_EN
    assign par_a = 1'b0;
    assign par_b = 1'b0;
    assign par_c = 1'b0;
    assign par_e = 1'b0;
`endif

    typedef struct {
        int          idx;
        logic [63:0] exp;
    } sb_t;

    sb_t   sb[$];
    int    total = 0;
    int    bad   = 0;
    string names[8] = '{"out_a", "out_b", "out_c", "out_e", "par_a", "par_b", "par_c", "par_e"};

    // Reference model state, power-up unknown.
    logic [31:0] m_a = 'x;
    logic [31:0] m_b = 'x;
    logic [3:0]  m_c = 'x;
    logic        m_e = 'x;

    task automatic push_all();
        sb.push_back('{0, 64'(m_a)});
        sb.push_back('{1, 64'(m_b)});
        sb.push_back('{2, 64'(m_c)});
        sb.push_back('{3, 64'(m_e)});
`ifdef REGISTER_PARITY_EN
        for (int k = 4; k < 8; k++) sb.push_back('{k, 64'(0)});
`endif
    endtask

    task automatic check_all();
        sb_t         t;
        logic [63:0] obs;
        while (sb.size() > 0) begin
            t = sb.pop_front();
            case (t.idx)
                0:       obs = 64'(out_a);
                1:       obs = 64'(out_b);
                2:       obs = 64'(out_c);
                3:       obs = 64'(out_e);
                4:       obs = 64'(par_a);
                5:       obs = 64'(par_b);
                6:       obs = 64'(par_c);
                default: obs = 64'(par_e);
            endcase
            total++;
            assert (obs === t.exp) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", names[t.idx], obs, t.exp);
            end
        end
    endtask

    // Drive one edge's inputs at the falling edge, update the model, check after the rising edge.
    task automatic step(input logic c, input logic e, input logic [31:0] d,
                        input logic [3:0] dd4, input logic dd1);
        @(negedge clk);
        clear_n = c;
        en      = e;
        d32     = d;
        d4      = dd4;
        d1      = dd1;
        if (!c) begin
            m_a = 32'h0;
            m_b = 32'h0000_0010;
            m_c = 4'h0;
            m_e = 1'b0;
        end else if (e) begin
            m_a = d;
            m_b = d;
            m_c = dd4;
            m_e = dd1;
        end
        push_all();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Disturb data mid-cycle; outputs must keep the previously written value.
    task automatic mid_check();
        #2;
        d32 = ~d32;
        d4  = ~d4;
        d1  = ~d1;
        #1;
        push_all();
        check_all();
    endtask

    initial begin
        clear_n = 1'b1;
        en      = 1'b0;
        d32     = '0;
        d4      = '0;
        d1      = 1'b0;

        // Reset with a write pending: clear wins.
        step(1'b0, 1'b1, 32'hDEAD_BEEF, 4'hA, 1'b1);

        // Write then hold for three edges with junk data.
        step(1'b1, 1'b1, 32'h1234_5678, 4'hF, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'hFFFF_FFFF, 4'h0, 1'b0);

        // Clear and write on the same edge.
        step(1'b0, 1'b1, 32'hA5A5_A5A5, 4'h5, 1'b1);

        // Data toggling every cycle with enable held.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, i[0] ? 32'hAAAA_AAAA : 32'h5555_5555 + 32'(i), 4'(i * 3), i[0]);
            mid_check();
        end

        // Idempotent write of constant data.
        step(1'b1, 1'b1, 32'h0BAD_F00D, 4'h9, 1'b0);
        step(1'b1, 1'b1, 32'h0BAD_F00D, 4'h9, 1'b0);

`ifdef REGISTER_PARITY_EN
        step(1'b1, 1'b1, 32'h0000_0007, 4'h7, 1'b1);
        force dut_a.r_q = 32'h0000_0006;
        #1;
        total++;
        assert (par_a === 1'b1) else begin
            bad++;
            $error("FAIL par_corrupt observed=%b expected=1", par_a);
        end
        release dut_a.r_q;
        step(1'b0, 1'b0, 32'h0000_0007, 4'h7, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
